// File: rtl/dct_2d_ctrl.sv
// dct_2d_ctrl: sequencer for an 8x8 forward 2-D binDCT built from two
// external, non-stallable 1-D math pipelines (row unit, column unit).
// Rows go to the row unit, row results fill an 8x8 transpose buffer, and
// columns go to the column unit. Column results are queued in an output
// FIFO whose space is reserved in advance with credits.
// Optional build macro DCT_CTRL_PERF_EN adds blk_cnt / stall_cnt counters.
module dct_2d_ctrl #(
   parameter int LATENCY    = 17,
   parameter int FIFO_DEPTH = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [7:0][7:0]   s_data,
   output logic [7:0][7:0]   row_math_in,
   input  logic [7:0][15:0]  row_math_out,
   output logic [7:0][15:0]  col_math_in,
   input  logic [7:0][15:0]  col_math_out,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [7:0][15:0]  m_data,
   output logic              m_last,
   output logic              busy
`ifdef DCT_CTRL_PERF_EN
   ,
   output logic [15:0]       blk_cnt,
   output logic [15:0]       stall_cnt
`endif
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0] CRED_FULL = CW'(FIFO_DEPTH);

   localparam logic [1:0] ROW_IN   = 2'd0;
   localparam logic [1:0] ROW_WAIT = 2'd1;
   localparam logic [1:0] COL_OUT  = 2'd2;

   // FIFO pointer advance with wrap for non power-of-two depths
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(FIFO_DEPTH - 1)) begin
         return {PW{1'b0}};
      end else begin
         return p + PW'(1);
      end
   endfunction

   logic [1:0]                 state_r;
   logic [1:0]                 state_nxt_s;
   logic                       s_ready_r;
   logic                       busy_r;
   logic [2:0]                 row_cnt_r;
   logic [2:0]                 wr_cnt_r;
   logic [2:0]                 col_cnt_r;
   logic                       accept_s;
   logic                       issue_s;

   // Tag delay lines track which math-unit output cycles carry real data
   logic [LATENCY-1:0]         row_vld_r;
   logic [LATENCY-1:0][2:0]    row_idx_r;
   logic [LATENCY-1:0]         col_vld_r;
   logic [LATENCY-1:0]         col_last_r;
   logic [LATENCY-1:0]         row_vld_nxt_s;
   logic [LATENCY-1:0]         col_vld_nxt_s;
   logic                       row_wr_s;
   logic [2:0]                 row_wr_idx_s;
   logic                       push_s;
   logic                       push_last_s;

   logic [7:0][7:0][15:0]      tbuf_r;

   logic [CW-1:0]              credits_r;
   logic [128:0]               mem_r [FIFO_DEPTH];
   logic [PW-1:0]              rd_ptr_r;
   logic [PW-1:0]              wr_ptr_r;
   logic [CW-1:0]              mem_cnt_r;
   logic                       m_valid_r;
   logic [7:0][15:0]           m_data_r;
   logic                       m_last_r;
   logic                       pop_s;
   logic                       load_s;
   logic                       mem_rd_s;
   logic                       bypass_s;
   logic                       mem_wr_s;
   logic                       ovf_s;

   assign accept_s      = s_valid & s_ready_r;
   assign issue_s       = (state_r == COL_OUT) && (credits_r != {CW{1'b0}});
   assign row_wr_s      = row_vld_r[LATENCY-1];
   assign row_wr_idx_s  = row_idx_r[LATENCY-1];
   assign push_s        = col_vld_r[LATENCY-1];
   assign push_last_s   = col_last_r[LATENCY-1];
   assign row_vld_nxt_s = {row_vld_r[LATENCY-2:0], accept_s};
   assign col_vld_nxt_s = {col_vld_r[LATENCY-2:0], issue_s};

   // The output register refills from the FIFO, or directly from a push when the FIFO is empty
   assign pop_s    = m_valid_r & m_ready;
   assign load_s   = ~m_valid_r | pop_s;
   assign mem_rd_s = load_s & (mem_cnt_r != {CW{1'b0}});
   assign bypass_s = load_s & (mem_cnt_r == {CW{1'b0}}) & push_s;
   assign mem_wr_s = push_s & ~bypass_s;
   assign ovf_s    = mem_wr_s & ~mem_rd_s & (mem_cnt_r == CRED_FULL);

   assign s_ready = s_ready_r;
   assign busy    = busy_r;
   assign m_valid = m_valid_r;
   assign m_data  = m_data_r;
   assign m_last  = m_last_r;

   // Next-state decode of the block sequencer
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ROW_IN: begin
            if (accept_s && (row_cnt_r == 3'd7)) state_nxt_s = ROW_WAIT;
            else                                 state_nxt_s = ROW_IN;
         end
         ROW_WAIT: begin
            if (row_wr_s && (wr_cnt_r == 3'd7)) state_nxt_s = COL_OUT;
            else                                state_nxt_s = ROW_WAIT;
         end
         COL_OUT: begin
            if (issue_s && (col_cnt_r == 3'd7)) state_nxt_s = ROW_IN;
            else                                state_nxt_s = COL_OUT;
         end
         default: state_nxt_s = ROW_IN;
      endcase
   end

   // Sequencer state, counters and registered handshake/status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ROW_IN;
         s_ready_r <= 1'b0;
         busy_r    <= 1'b0;
         row_cnt_r <= 3'd0;
         wr_cnt_r  <= 3'd0;
         col_cnt_r <= 3'd0;
      end else begin
         state_r   <= state_nxt_s;
         s_ready_r <= (state_nxt_s == ROW_IN);
         busy_r    <= (state_nxt_s != ROW_IN) | (|row_vld_nxt_s) | (|col_vld_nxt_s);
         if (accept_s) row_cnt_r <= row_cnt_r + 3'd1;
         if (row_wr_s) wr_cnt_r  <= wr_cnt_r + 3'd1;
         if (issue_s)  col_cnt_r <= col_cnt_r + 3'd1;
      end
   end

   // Row and column tag delay lines, aligned with the math pipeline latency
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_vld_r  <= {LATENCY{1'b0}};
         row_idx_r  <= {(LATENCY*3){1'b0}};
         col_vld_r  <= {LATENCY{1'b0}};
         col_last_r <= {LATENCY{1'b0}};
      end else begin
         row_vld_r  <= row_vld_nxt_s;
         row_idx_r  <= {row_idx_r[LATENCY-2:0], row_cnt_r};
         col_vld_r  <= col_vld_nxt_s;
         col_last_r <= {col_last_r[LATENCY-2:0], issue_s && (col_cnt_r == 3'd7)};
      end
   end

   // Transpose buffer: whole row results written by row index
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tbuf_r <= {1024{1'b0}};
      end else if (row_wr_s) begin
         tbuf_r[row_wr_idx_s] <= row_math_out;
      end
   end

   // Row unit feed: pass the accepted row through, zero otherwise
   always_comb begin
      if (accept_s) row_math_in = s_data;
      else          row_math_in = {64{1'b0}};
   end

   // Column unit feed: read one buffer column while a credit is available
   always_comb begin
      col_math_in = {128{1'b0}};
      for (int r = 0; r < 8; r++) begin
         if (issue_s) col_math_in[r] = tbuf_r[r][col_cnt_r];
         else         col_math_in[r] = 16'd0;
      end
   end

   // Credits reserve FIFO space before a column enters the non-stallable column unit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credits_r <= CRED_FULL;
      end else begin
         case ({issue_s, pop_s})
            2'b10:   credits_r <= credits_r - CW'(1);
            2'b01:   credits_r <= credits_r + CW'(1);
            default: credits_r <= credits_r;
         endcase
      end
   end

   // FIFO storage; contents are qualified by pointers and count, so no reset is needed
   always_ff @(posedge clk) begin
      if (mem_wr_s) mem_r[wr_ptr_r] <= {push_last_s, col_math_out};
   end

   // FIFO pointers, occupancy and the registered head (m_valid/m_data/m_last)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_r  <= {PW{1'b0}};
         wr_ptr_r  <= {PW{1'b0}};
         mem_cnt_r <= {CW{1'b0}};
         m_valid_r <= 1'b0;
         m_data_r  <= {128{1'b0}};
         m_last_r  <= 1'b0;
      end else begin
         if (mem_wr_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
         if (mem_rd_s) rd_ptr_r <= ptr_inc(rd_ptr_r);
         mem_cnt_r <= mem_cnt_r + CW'(mem_wr_s) - CW'(mem_rd_s);
         if (load_s) begin
            if (mem_rd_s) begin
               m_valid_r <= 1'b1;
               m_data_r  <= mem_r[rd_ptr_r][127:0];
               m_last_r  <= mem_r[rd_ptr_r][128];
            end else if (push_s) begin
               m_valid_r <= 1'b1;
               m_data_r  <= col_math_out;
               m_last_r  <= push_last_s;
            end else begin
               m_valid_r <= 1'b0;
               m_data_r  <= {128{1'b0}};
               m_last_r  <= 1'b0;
            end
         end
      end
   end

`ifdef DCT_CTRL_PERF_EN
   logic [15:0] blk_cnt_r;
   logic [15:0] stall_cnt_r;

   assign blk_cnt   = blk_cnt_r;
   assign stall_cnt = stall_cnt_r;

   // Completed-block counter (wrapping) and credit-stall counter (saturating)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blk_cnt_r   <= 16'd0;
         stall_cnt_r <= 16'd0;
      end else begin
         if (pop_s && m_last_r) blk_cnt_r <= blk_cnt_r + 16'd1;
         if ((state_r == COL_OUT) && !issue_s && (stall_cnt_r != 16'hFFFF))
            stall_cnt_r <= stall_cnt_r + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dct_2d_ctrl.sv
// Bench for dct_2d_ctrl: behavioural row/column math pipelines (Hadamard-
// structured integer butterflies, DC term = plain sum) drive the DUT; beats
// are compared against a bench-side 2-D model and hand-derived constants.
module tb_dct_2d_ctrl;
   localparam int LAT   = 17;
   localparam int DEPTH = 8;

   typedef logic [7:0][7:0]       row_t;
   typedef logic [7:0][15:0]      vec_t;
   typedef logic [7:0][7:0][7:0]  blk_t;
   typedef logic [7:0][7:0][15:0] cblk_t;

   logic clk;
   logic rst_n;
   logic s_valid;
   logic s_ready;
   row_t s_data;
   row_t row_math_in;
   vec_t row_math_out;
   vec_t col_math_in;
   vec_t col_math_out;
   logic m_valid;
   logic m_ready;
   vec_t m_data;
   logic m_last;
   logic busy;
`ifdef DCT_CTRL_PERF_EN
   logic [15:0] blk_cnt;
   logic [15:0] stall_cnt;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   dct_2d_ctrl #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .row_math_in(row_math_in), .row_math_out(row_math_out),
      .col_math_in(col_math_in), .col_math_out(col_math_out),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .busy(busy)
`ifdef DCT_CTRL_PERF_EN
      , .blk_cnt(blk_cnt), .stall_cnt(stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int sgn(input int k, input int n);
      logic [2:0] a;
      a = 3'(k & n);
      return (^a) ? -1 : 1;
   endfunction

   function automatic vec_t row_f(input row_t x);
      vec_t y;
      for (int k = 0; k < 8; k++) begin
         int acc = 0;
         for (int n = 0; n < 8; n++) acc += sgn(k, n) * int'($signed(x[n]));
         y[k] = 16'(acc);
      end
      return y;
   endfunction

   function automatic vec_t col_f(input vec_t x);
      vec_t y;
      for (int k = 0; k < 8; k++) begin
         int acc = 0;
         for (int n = 0; n < 8; n++) acc += sgn(k, n) * int'($signed(x[n]));
         y[k] = 16'(acc);
      end
      return y;
   endfunction

   // golden[k][v]: beat k (column k), coefficient v (vertical frequency)
   function automatic cblk_t golden(input blk_t b);
      vec_t  rr [8];
      vec_t  cv;
      cblk_t g;
      for (int r = 0; r < 8; r++) rr[r] = row_f(b[r]);
      for (int k = 0; k < 8; k++) begin
         for (int r = 0; r < 8; r++) cv[r] = rr[r][k];
         g[k] = col_f(cv);
      end
      return g;
   endfunction

   // Behavioural math units: fixed LAT-cycle pipelines
   vec_t rpipe [LAT];
   vec_t cpipe [LAT];
   always @(posedge clk) begin
      rpipe[0] <= row_f(row_math_in);
      cpipe[0] <= col_f(col_math_in);
      for (int i = 1; i < LAT; i++) begin
         rpipe[i] <= rpipe[i-1];
         cpipe[i] <= cpipe[i-1];
      end
   end
   assign row_math_out = rpipe[LAT-1];
   assign col_math_out = cpipe[LAT-1];

   // Beat collector, cycle counter, issue counter and overflow monitor
   int           cyc       = 0;
   int           issue_cnt = 0;
   bit           ovf_seen  = 1'b0;
   logic [127:0] q_data [$];
   logic         q_last [$];
   int           q_cyc  [$];
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (m_valid && m_ready) begin
         q_data.push_back(m_data);
         q_last.push_back(m_last);
         q_cyc.push_back(cyc);
      end
      if (dut.issue_s) issue_cnt <= issue_cnt + 1;
      if (dut.ovf_s)   ovf_seen  <= 1'b1;
   end

   task automatic send_block(input blk_t b, output int t_first);
      t_first = -1;
      for (int r = 0; r < 8; r++) begin
         int g;
         g = 0;
         s_valid = 1'b1;
         s_data  = b[r];
         while (!s_ready && g < 300) begin
            @(negedge clk);
            g++;
         end
         n_cmp++;
         if (s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_row%0d_timeout: s_ready=%b required 1", r, s_ready);
         end
         if (r == 0) t_first = cyc;
         @(negedge clk);
      end
      s_valid = 1'b0;
      s_data  = 64'd0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; s_valid = 1'b0; s_data = 64'd0; m_ready = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp += 7;
      if (s_ready !== 1'b0)         begin n_fail++; $display("FAIL rst_s_ready: got %b required 0", s_ready); end
      if (m_valid !== 1'b0)         begin n_fail++; $display("FAIL rst_m_valid: got %b required 0", m_valid); end
      if (m_last !== 1'b0)          begin n_fail++; $display("FAIL rst_m_last: got %b required 0", m_last); end
      if (m_data !== 128'd0)        begin n_fail++; $display("FAIL rst_m_data: got %h required 0", m_data); end
      if (busy !== 1'b0)            begin n_fail++; $display("FAIL rst_busy: got %b required 0", busy); end
      if (row_math_in !== 64'd0)    begin n_fail++; $display("FAIL rst_row_in: got %h required 0", row_math_in); end
      if (col_math_in !== 128'd0)   begin n_fail++; $display("FAIL rst_col_in: got %h required 0", col_math_in); end
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp += 2;
      if (s_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_s_ready: got %b required 1", s_ready); end
      if (busy !== 1'b0)    begin n_fail++; $display("FAIL post_rst_busy: got %b required 0", busy); end
   endtask

   task automatic test_const();
      blk_t         b;
      int           t0, qb, g;
      logic [127:0] exp;
      m_ready = 1'b1;
      qb = q_data.size();
      for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) b[r][c] = 8'd10;
      send_block(b, t0);
      g = 0;
      while (q_data.size() < qb + 8 && g < 400) begin @(negedge clk); g++; end
      n_cmp++;
      if (q_data.size() != qb + 8) begin
         n_fail++; $display("FAIL const_beats: got %0d required 8", q_data.size() - qb);
      end else begin
         for (int i = 0; i < 8; i++) begin
            exp = 128'd0;
            if (i == 0) exp[15:0] = 16'd640;
            n_cmp += 3;
            if (q_data[qb+i] !== exp) begin n_fail++; $display("FAIL const_data%0d: got %h required %h", i, q_data[qb+i], exp); end
            if (q_cyc[qb+i] - t0 != 43 + i) begin n_fail++; $display("FAIL const_cycle%0d: got %0d required %0d", i, q_cyc[qb+i] - t0, 43 + i); end
            if (q_last[qb+i] !== (i == 7)) begin n_fail++; $display("FAIL const_last%0d: got %b required %b", i, q_last[qb+i], (i == 7)); end
         end
      end
      @(negedge clk);
      n_cmp += 2;
      if (busy !== 1'b0)    begin n_fail++; $display("FAIL const_idle_busy: got %b required 0", busy); end
      if (m_valid !== 1'b0) begin n_fail++; $display("FAIL const_idle_m_valid: got %b required 0", m_valid); end
   endtask

   task automatic test_impulse();
      blk_t  b;
      cblk_t gd;
      int    t0, qb, g;
      m_ready = 1'b1;
      qb = q_data.size();
      b = 512'd0;
      b[2][5] = 8'd8;
      gd = golden(b);
      send_block(b, t0);
      g = 0;
      while (q_data.size() < qb + 8 && g < 400) begin @(negedge clk); g++; end
      n_cmp++;
      if (q_data.size() != qb + 8) begin
         n_fail++; $display("FAIL imp_beats: got %0d required 8", q_data.size() - qb);
      end else begin
         for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (q_data[qb+i] !== gd[i]) begin n_fail++; $display("FAIL imp_col%0d: got %h required %h", i, q_data[qb+i], gd[i]); end
         end
         n_cmp += 2;
         if (q_data[qb][15:0] !== 16'd8)     begin n_fail++; $display("FAIL imp_c0v0: got %h required 0008", q_data[qb][15:0]); end
         if (q_data[qb+5][47:32] !== 16'hFFF8) begin n_fail++; $display("FAIL imp_c5v2: got %h required fff8", q_data[qb+5][47:32]); end
      end
   endtask

   task automatic test_back_to_back();
      blk_t  a, b;
      cblk_t ga, gb;
      int    ta, tb, qb, g;
      m_ready = 1'b1;
      qb = q_data.size();
      for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) begin
         a[r][c] = 8'(r * 8 + c - 20);
         b[r][c] = 8'(c * 5 - r * 7);
      end
      ga = golden(a);
      gb = golden(b);
      send_block(a, ta);
      send_block(b, tb);
      n_cmp++;
      if (tb - ta != 33) begin n_fail++; $display("FAIL b2b_second_start: got %0d required 33", tb - ta); end
      g = 0;
      while (q_data.size() < qb + 16 && g < 400) begin @(negedge clk); g++; end
      n_cmp++;
      if (q_data.size() != qb + 16) begin
         n_fail++; $display("FAIL b2b_beats: got %0d required 16", q_data.size() - qb);
      end else begin
         for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (i < 8) begin
               if (q_data[qb+i] !== ga[i]) begin n_fail++; $display("FAIL b2b_blk1_col%0d: got %h required %h", i, q_data[qb+i], ga[i]); end
            end else begin
               if (q_data[qb+i] !== gb[i-8]) begin n_fail++; $display("FAIL b2b_blk2_col%0d: got %h required %h", i - 8, q_data[qb+i], gb[i-8]); end
            end
         end
      end
   endtask

   task automatic test_fifo_backpressure();
      blk_t  b;
      cblk_t gd;
      int    t0, qb, ib, g, tr;
      m_ready = 1'b0;
      qb = q_data.size();
      ib = issue_cnt;
      for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) b[r][c] = 8'(63 - r * 9 - c);
      gd = golden(b);
      send_block(b, t0);
      g = 0;
      while (cyc < t0 + 32 && g < 200) begin @(negedge clk); g++; end
      n_cmp++;
      if (s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_s_ready_c32: got %b required 0", s_ready); end
      @(negedge clk);
      n_cmp++;
      if (s_ready !== 1'b1) begin n_fail++; $display("FAIL bp_s_ready_c33: got %b required 1", s_ready); end
      g = 0;
      while (cyc < t0 + 100 && g < 200) begin @(negedge clk); g++; end
      n_cmp += 3;
      if (issue_cnt - ib != 8)    begin n_fail++; $display("FAIL bp_issues: got %0d required 8", issue_cnt - ib); end
      if (q_data.size() != qb)    begin n_fail++; $display("FAIL bp_no_beats: got %0d required 0", q_data.size() - qb); end
      if (m_valid !== 1'b1)       begin n_fail++; $display("FAIL bp_m_valid: got %b required 1", m_valid); end
      m_ready = 1'b1;
      tr = cyc;
      g = 0;
      while (q_data.size() < qb + 8 && g < 100) begin @(negedge clk); g++; end
      n_cmp++;
      if (q_data.size() != qb + 8) begin
         n_fail++; $display("FAIL bp_drain: got %0d required 8", q_data.size() - qb);
      end else begin
         for (int i = 0; i < 8; i++) begin
            n_cmp += 3;
            if (q_data[qb+i] !== gd[i])     begin n_fail++; $display("FAIL bp_col%0d: got %h required %h", i, q_data[qb+i], gd[i]); end
            if (q_cyc[qb+i] != tr + i)      begin n_fail++; $display("FAIL bp_cycle%0d: got %0d required %0d", i, q_cyc[qb+i] - tr, i); end
            if (q_last[qb+i] !== (i == 7))  begin n_fail++; $display("FAIL bp_last%0d: got %b required %b", i, q_last[qb+i], (i == 7)); end
         end
      end
   endtask

   task automatic test_reset_mid();
      blk_t  d, e;
      cblk_t ge;
      int    t0, qb, ib, g;
      m_ready = 1'b1;
      ib = issue_cnt;
      for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) begin
         d[r][c] = 8'(r + c + 1);
         e[r][c] = 8'((r * c) - 17);
      end
      ge = golden(e);
      send_block(d, t0);
      g = 0;
      while (cyc < t0 + 30 && g < 200) begin @(negedge clk); g++; end
      n_cmp++;
      if (issue_cnt - ib != 5) begin n_fail++; $display("FAIL rm_issued_before: got %0d required 5", issue_cnt - ib); end
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp += 5;
      if (s_ready !== 1'b0)       begin n_fail++; $display("FAIL rm_s_ready: got %b required 0", s_ready); end
      if (m_valid !== 1'b0)       begin n_fail++; $display("FAIL rm_m_valid: got %b required 0", m_valid); end
      if (m_data !== 128'd0)      begin n_fail++; $display("FAIL rm_m_data: got %h required 0", m_data); end
      if (busy !== 1'b0)          begin n_fail++; $display("FAIL rm_busy: got %b required 0", busy); end
      if (col_math_in !== 128'd0) begin n_fail++; $display("FAIL rm_col_in: got %h required 0", col_math_in); end
      rst_n = 1'b1;
      qb = q_data.size();
      ib = issue_cnt;
      repeat (40) @(negedge clk);
      n_cmp += 4;
      if (q_data.size() != qb) begin n_fail++; $display("FAIL rm_stale_beats: got %0d required 0", q_data.size() - qb); end
      if (issue_cnt != ib)     begin n_fail++; $display("FAIL rm_stale_issue: got %0d required 0", issue_cnt - ib); end
      if (m_valid !== 1'b0)    begin n_fail++; $display("FAIL rm_stale_m_valid: got %b required 0", m_valid); end
      if (busy !== 1'b0)       begin n_fail++; $display("FAIL rm_idle_busy: got %b required 0", busy); end
      send_block(e, t0);
      g = 0;
      while (q_data.size() < qb + 8 && g < 400) begin @(negedge clk); g++; end
      n_cmp++;
      if (q_data.size() != qb + 8) begin
         n_fail++; $display("FAIL rm_next_beats: got %0d required 8", q_data.size() - qb);
      end else begin
         for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (q_data[qb+i] !== ge[i]) begin n_fail++; $display("FAIL rm_next_col%0d: got %h required %h", i, q_data[qb+i], ge[i]); end
         end
      end
   endtask

`ifdef DCT_CTRL_PERF_EN
   task automatic test_perf();
      blk_t a, b, c;
      int   tp, t1, t2, t3, qb, g;
      rst_n = 1'b0; m_ready = 1'b0; s_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int r = 0; r < 8; r++) for (int k = 0; k < 8; k++) begin
         a[r][k] = 8'(r - k);
         b[r][k] = 8'(2 * r + k);
         c[r][k] = 8'(k * k - r);
      end
      qb = q_data.size();
      tp = cyc;
      fork
         begin
            send_block(a, t1);
            send_block(b, t2);
            send_block(c, t3);
         end
         begin
            repeat (80) @(negedge clk);
            m_ready = 1'b1;
         end
      join
      g = 0;
      while (q_data.size() < qb + 24 && g < 400) begin @(negedge clk); g++; end
      @(negedge clk);
      n_cmp += 4;
      if (t1 != tp)                begin n_fail++; $display("FAIL perf_start: got %0d required %0d", t1, tp); end
      if (q_data.size() != qb + 24) begin n_fail++; $display("FAIL perf_beats: got %0d required 24", q_data.size() - qb); end
      if (blk_cnt !== 16'd3)       begin n_fail++; $display("FAIL perf_blk_cnt: got %0d required 3", blk_cnt); end
      if (stall_cnt !== 16'd23)    begin n_fail++; $display("FAIL perf_stall_cnt: got %0d required 23", stall_cnt); end
   endtask
`endif

   initial begin
      rst_n = 1'b0; s_valid = 1'b0; s_data = 64'd0; m_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_const();
      test_impulse();
      test_back_to_back();
      test_fifo_backpressure();
      test_reset_mid();
`ifdef DCT_CTRL_PERF_EN
      test_perf();
`endif
      n_cmp++;
      if (ovf_seen !== 1'b0) begin n_fail++; $display("FAIL fifo_overflow: got %b required 0", ovf_seen); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
